decode_issue_ctrl: RTL and testbench

DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

---
 rtl/decode_issue_ctrl_pkg.sv | 27 ++
 rtl/decode_issue_ctrl_if.sv | 30 +++
 rtl/decode_issue_ctrl_ibuf_fifo2.sv | 56 +++++
 rtl/decode_issue_ctrl.sv | 60 ++++++
 tb/tb_decode_issue_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared core defines: opcodes, NOP encoding, buffer depth and
// source-register usage helpers for the decode/issue controller.
package decode_issue_ctrl_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I_IMME  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;
    localparam logic [6:0] OP_J_JALR  = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned IBUF_DEPTH = 2;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I_IMME) || (op == OP_I_LOAD) ||
               (op == OP_S) || (op == OP_B) || (op == OP_J_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_S) || (op == OP_B);
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch/issue/execute handshake bundle for decode_issue_ctrl.
// master drives fetch and downstream inputs; slave is the controller.
interface decode_issue_ctrl_if;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        issue_ready;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        flush;
    logic        hazard_stall;

    modport master (
        output if_valid, if_instr, if_pc, issue_ready,
        output ex_load_valid, ex_load_rd, flush,
        input  if_ready, issue_valid, issue_instr, issue_pc, hazard_stall
    );

    modport slave (
        input  if_valid, if_instr, if_pc, issue_ready,
        input  ex_load_valid, ex_load_rd, flush,
        output if_ready, issue_valid, issue_instr, issue_pc, hazard_stall
    );

endinterface

// File: rtl/decode_issue_ctrl_ibuf_fifo2.sv
// Two-entry in-order instruction buffer (ibuf_fifo2) with 1-bit
// pointers; head shows NOP/pc 0 when empty.
module ibuf_fifo2
    import decode_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    output logic [1:0]  count,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc
);

    logic [31:0] mem_instr [IBUF_DEPTH];
    logic [31:0] mem_pc    [IBUF_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            mem_instr[0] <= NOP_INSTR;
            mem_instr[1] <= NOP_INSTR;
            mem_pc[0]    <= 32'd0;
            mem_pc[1]    <= 32'd0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= push_instr;
                mem_pc[wr_ptr]    <= push_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_instr = (count == 2'd0) ? NOP_INSTR : mem_instr[rd_ptr];
    assign head_pc    = (count == 2'd0) ? 32'd0 : mem_pc[rd_ptr];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: buffered fetch handshake plus load-use
// interlock, compiled in only when HAZARD_CHECK_EN is defined.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    decode_issue_ctrl_if.slave   bus
);

    logic [1:0]  count;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        push;
    logic        pop;
    logic        stall;
    logic        not_empty;

    assign not_empty   = (count != 2'd0);
    assign bus.if_ready = (count != 2'(IBUF_DEPTH)) && !bus.flush;
    assign push        = bus.if_valid && bus.if_ready;
    assign pop         = bus.issue_valid && bus.issue_ready;

    ibuf_fifo2 u_ibuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (bus.flush),
        .push_instr (bus.if_instr),
        .push_pc    (bus.if_pc),
        .count      (count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

`ifdef HAZARD_CHECK_EN
    logic [6:0] opcode;
    logic       rs1_hit;
    logic       rs2_hit;

    assign opcode  = head_instr[6:0];
    assign rs1_hit = uses_rs1(opcode) &&
                     (head_instr[19:15] == bus.ex_load_rd);
    assign rs2_hit = uses_rs2(opcode) &&
                     (head_instr[24:20] == bus.ex_load_rd);
    assign stall   = not_empty && bus.ex_load_valid &&
                     (bus.ex_load_rd != 5'd0) && (rs1_hit || rs2_hit);
`else
    logic unused_load;
    assign unused_load = ^{bus.ex_load_valid, bus.ex_load_rd};
    assign stall       = 1'b0;
`endif

    assign bus.hazard_stall = stall;
    assign bus.issue_valid  = not_empty && !stall && !bus.flush;
    assign bus.issue_instr  = head_instr;
    assign bus.issue_pc     = head_pc;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl.
// Hazard expectations follow HAZARD_CHECK_EN.
module tb_decode_issue_ctrl;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    decode_issue_ctrl_if bus ();

    decode_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.if_valid      = 1'b0;
        bus.if_instr      = 32'd0;
        bus.if_pc         = 32'd0;
        bus.issue_ready   = 1'b0;
        bus.ex_load_valid = 1'b0;
        bus.ex_load_rd    = 5'd0;
        bus.flush         = 1'b0;
        #2;
        chk("rst_if_ready", 32'(bus.if_ready), 32'd1);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_stall", 32'(bus.hazard_stall), 32'd0);
        chk("rst_instr", bus.issue_instr, 32'h00000013);
        chk("rst_pc", bus.issue_pc, 32'd0);
        bus.flush = 1'b1;
        #1;
        chk("rst_flush_if_ready", 32'(bus.if_ready), 32'd0);
        bus.flush = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // single word, one-cycle latency then pop
        bus.if_valid    = 1'b1;
        bus.if_instr    = 32'h00500093;
        bus.if_pc       = 32'h100;
        bus.issue_ready = 1'b1;
        #1;
        chk("lat_no_bypass", 32'(bus.issue_valid), 32'd0);
        step();
        bus.if_valid = 1'b0;
        #1;
        chk("lat_valid", 32'(bus.issue_valid), 32'd1);
        chk("lat_instr", bus.issue_instr, 32'h00500093);
        chk("lat_pc", bus.issue_pc, 32'h100);
        step();
        chk("pop_empty_valid", 32'(bus.issue_valid), 32'd0);
        chk("pop_empty_instr", bus.issue_instr, 32'h00000013);

        // fill to two, third word held by fetch, then drain
        bus.issue_ready = 1'b0;
        bus.if_valid    = 1'b1;
        bus.if_instr    = 32'h00500093;
        bus.if_pc       = 32'h200;
        step();
        chk("fill1_if_ready", 32'(bus.if_ready), 32'd1);
        bus.if_instr = 32'h00100113;
        bus.if_pc    = 32'h204;
        step();
        bus.if_instr = 32'h00200193;
        bus.if_pc    = 32'h208;
        #1;
        chk("full_if_ready", 32'(bus.if_ready), 32'd0);
        chk("full_head", bus.issue_instr, 32'h00500093);
        step();
        chk("held_head", bus.issue_instr, 32'h00500093);
        bus.issue_ready = 1'b1;
        #1;
        chk("full_pop_if_ready", 32'(bus.if_ready), 32'd0);
        chk("drain_a_pc", bus.issue_pc, 32'h200);
        step();
        chk("drain_b_instr", bus.issue_instr, 32'h00100113);
        chk("drain_b_if_ready", 32'(bus.if_ready), 32'd1);
        step();
        bus.if_valid = 1'b0;
        #1;
        chk("drain_c_instr", bus.issue_instr, 32'h00200193);
        chk("drain_c_pc", bus.issue_pc, 32'h208);
        chk("drain_c_valid", 32'(bus.issue_valid), 32'd1);
        step();
        chk("drained_valid", 32'(bus.issue_valid), 32'd0);

        // load-use hazard on add x3,x1,x2
        bus.issue_ready = 1'b0;
        bus.if_valid    = 1'b1;
        bus.if_instr    = 32'h002081B3;
        bus.if_pc       = 32'h300;
        step();
        bus.if_valid      = 1'b0;
        bus.ex_load_valid = 1'b1;
        bus.ex_load_rd    = 5'd1;
        #1;
`ifdef HAZARD_CHECK_EN
        chk("hz_rs1_stall", 32'(bus.hazard_stall), 32'd1);
        chk("hz_rs1_valid", 32'(bus.issue_valid), 32'd0);
        bus.ex_load_rd = 5'd2;
        #1;
        chk("hz_rs2_stall", 32'(bus.hazard_stall), 32'd1);
`else
        chk("nohz_stall", 32'(bus.hazard_stall), 32'd0);
        chk("nohz_valid", 32'(bus.issue_valid), 32'd1);
`endif
        bus.ex_load_rd = 5'd0;
        #1;
        chk("hz_rd0_valid", 32'(bus.issue_valid), 32'd1);
        bus.ex_load_rd = 5'd5;
        #1;
        chk("hz_rd5_valid", 32'(bus.issue_valid), 32'd1);
        chk("hz_rd5_stall", 32'(bus.hazard_stall), 32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;

        // lui uses no source register
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h000010B7;
        bus.if_pc    = 32'h400;
        step();
        bus.if_valid   = 1'b0;
        bus.ex_load_rd = 5'd1;
        #1;
        chk("lui_stall", 32'(bus.hazard_stall), 32'd0);
        chk("lui_valid", 32'(bus.issue_valid), 32'd1);
        bus.ex_load_valid = 1'b0;

        // flush on a full buffer
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h00400213;
        bus.if_pc    = 32'h404;
        step();
        bus.flush = 1'b1;
        #1;
        chk("flush_if_ready", 32'(bus.if_ready), 32'd0);
        chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        step();
        bus.flush    = 1'b0;
        bus.if_valid = 1'b0;
        #1;
        chk("post_flush_valid", 32'(bus.issue_valid), 32'd0);
        chk("post_flush_instr", bus.issue_instr, 32'h00000013);
        chk("post_flush_pc", bus.issue_pc, 32'd0);
        chk("post_flush_if_ready", 32'(bus.if_ready), 32'd1);

        // asynchronous reset with two entries buffered
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h00500093;
        bus.if_pc    = 32'h500;
        step();
        step();
        bus.if_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(bus.issue_valid), 32'd1);
        chk("pre_rst_if_ready", 32'(bus.if_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("async_rst_instr", bus.issue_instr, 32'h00000013);
        chk("async_rst_if_ready", 32'(bus.if_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("post_rst_pc", bus.issue_pc, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
